// File: rtl/dmem_dump_pkg.sv
// ----------------------------------------------------------------------------
// x9_pkg -- shared definitions for the data-memory dump engine.
//
// Holds the dump FSM state encoding, the default address/data widths (shared
// with the data memory itself) and the beat record type used by consumers of
// the dump stream.
//
// Optional feature macro seen by users of this package: DMEM_DUMP_CHECKSUM_EN
// (adds the ST_CSUM state to the walk; the encoding is always present so the
// enum is identical in both builds).
// ----------------------------------------------------------------------------
package x9_pkg;

    // Default data-memory geometry: 256 bytes, byte wide.
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    // Dump walk states. ST_CSUM is only reachable when the checksum beat is
    // compiled in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_FIN   = 3'd5
    } dump_state_t;

    // One beat of the output stream at the default geometry.
    typedef struct packed {
        logic [DW_DEF-1:0] data;
        logic [AW_DEF-1:0] addr;
        logic              last;
    } beat_t;

endpackage : x9_pkg

// File: rtl/dmem_dump_if.sv
// ----------------------------------------------------------------------------
// dmem_dump_if -- valid/ready byte stream carrying dumped data memory.
//
// Signals:
//   tx_valid  source -> sink  beat valid
//   tx_ready  sink -> source  sink accepts beat when high with tx_valid
//   tx_data   source -> sink  byte
//   tx_addr   source -> sink  data-memory address of the byte
//   tx_last   source -> sink  final beat of the dump
//
// Modports: master (the dump engine), slave (host / bench consumer).
// ----------------------------------------------------------------------------
interface dmem_dump_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();

    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic [AW-1:0] tx_addr;
    logic          tx_last;

    modport master (
        output tx_valid,
        output tx_data,
        output tx_addr,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  tx_addr,
        input  tx_last,
        output tx_ready
    );

endinterface : dmem_dump_if

// File: rtl/dmem_dump.sv
// ----------------------------------------------------------------------------
// dmem_dump -- read-out engine for the byte-wide data memory.
//
// On a start pulse in IDLE it latches a base address and a byte count, then
// walks that window of data memory through the memory's spare read port and
// streams every byte, tagged with its address, over a valid/ready port. The
// window wraps modulo DEPTH, so length == DEPTH dumps the whole memory.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-low
//   start      one-cycle dump request, only honoured in IDLE
//   base_addr  first address (sampled with start)
//   length     byte count 0..DEPTH (sampled with start)
//   mem_rd_en  read strobe to the data-memory spare port
//   mem_addr   read address, holds while mem_rd_en is low
//   mem_rdata  read data, valid one cycle after mem_rd_en
//   tx         dmem_dump_if.master output stream
//   busy       high whenever the FSM is not idle
//   finished   one-cycle pulse at the end of a dump
//
// Configuration macro: DMEM_DUMP_CHECKSUM_EN
//   When defined, one extra beat follows the data beats carrying the XOR of
//   all dumped bytes, addressed at the address after the last byte; tx_last
//   moves onto that beat. A zero-length dump then emits a lone 0x00 beat.
//
// All outputs are registers or decodes of the state register; nothing from
// start or tx_ready reaches an output combinationally.
// ----------------------------------------------------------------------------
module dmem_dump
    import x9_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    dmem_dump_if.master   tx,
    output logic          busy,
    output logic          finished
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    dump_state_t   state_reg;
    dump_state_t   state_next;

    logic [AW-1:0] addr_reg;       // address of the byte currently in flight
    logic [AW:0]   remaining_reg;  // bytes not yet handed off, incl. current
    logic [AW-1:0] mem_addr_reg;   // read address presented to the memory
    logic [DW-1:0] tx_data_reg;
    logic [AW-1:0] tx_addr_reg;
    logic          tx_last_reg;

`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [DW-1:0] csum_reg;       // running XOR of bytes read so far
`endif

    // Derived helpers
    logic          handshake;
    logic          last_data;      // the beat in SEND is the final data byte
    logic [AW-1:0] addr_inc;       // wraps naturally at DEPTH

    assign handshake = tx.tx_ready;
    assign last_data = (remaining_reg == (AW+1)'(1));
    assign addr_inc  = addr_reg + 1'b1;

    // ------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        // Nothing to read, but the checksum beat is still owed.
                        state_next = ST_CSUM;
`else
                        state_next = ST_FIN;
`endif
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_SEND;
            ST_SEND: begin
                if (handshake) begin
                    if (last_data) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_FIN;
`endif
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_CSUM: begin
                if (handshake) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: outputs, decoded from state or taken from registers
    // ------------------------------------------------------------------
    always_comb begin
        mem_rd_en   = (state_reg == ST_ISSUE);
        mem_addr    = mem_addr_reg;
        tx.tx_valid = (state_reg == ST_SEND) || (state_reg == ST_CSUM);
        tx.tx_data  = tx_data_reg;
        tx.tx_addr  = tx_addr_reg;
        tx.tx_last  = tx_last_reg;
        busy        = (state_reg != ST_IDLE);
        finished    = (state_reg == ST_FIN);
    end

    // ------------------------------------------------------------------
    // Datapath: address/count walk, beat capture, optional checksum
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            mem_addr_reg  <= '0;
            tx_data_reg   <= '0;
            tx_addr_reg   <= '0;
            tx_last_reg   <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        addr_reg      <= base_addr;
                        remaining_reg <= length;
                        // mem_addr only moves when a read is about to issue.
                        if (length != '0) begin
                            mem_addr_reg <= base_addr;
                        end
`ifdef DMEM_DUMP_CHECKSUM_EN
                        csum_reg <= '0;
                        if (length == '0) begin
                            tx_data_reg <= '0;
                            tx_addr_reg <= base_addr;
                            tx_last_reg <= 1'b1;
                        end
`endif
                    end
                end

                ST_WAIT: begin
                    // Read data from the ISSUE cycle is on mem_rdata now.
                    tx_data_reg <= mem_rdata;
                    tx_addr_reg <= addr_reg;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    tx_last_reg <= 1'b0;
                    csum_reg    <= csum_reg ^ mem_rdata;
`else
                    tx_last_reg <= last_data;
`endif
                end

                ST_SEND: begin
                    if (handshake) begin
                        remaining_reg <= remaining_reg - 1'b1;
                        addr_reg      <= addr_inc;
                        if (!last_data) begin
                            mem_addr_reg <= addr_inc;
                        end
`ifdef DMEM_DUMP_CHECKSUM_EN
                        // csum_reg already includes the byte in this beat.
                        if (last_data) begin
                            tx_data_reg <= csum_reg;
                            tx_addr_reg <= addr_inc;
                            tx_last_reg <= 1'b1;
                        end
`endif
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule : dmem_dump
